// File: rtl/ecc_scrubber_64_57.sv
`timescale 1ns/1ps
// SECDED 64/57 memory scrubber: walks every address, checks each codeword, writes back corrected words.
// Latency: 3 cycles per clean address when the read is acked immediately (RD, CHK, NEXT); +FIX cycles on a correctable error.
// Backpressure: o_MemReq / o_FixReq are held (address/data stable) until i_MemAck / i_FixAck; i_Abort drops them next cycle.
//
// Ports: i_Clk/i_Rst (async active-high); i_Start/i_Abort/i_Continuous/i_ClrCnt control;
// memory read port o_MemReq/o_MemAddr/i_MemAck/i_MemData; write-back port o_FixReq/o_FixAddr/o_FixData/i_FixAck;
// status o_Busy/o_Done, error counters o_CorrCnt/o_UncorrCnt, first-error capture o_FirstErrAddr/o_FirstErrValid.

// Extended Hamming decoder. Codeword layout: bit 0 = overall parity, bits at power-of-two
// positions 1..32 = Hamming parity, remaining 57 positions = data bits in ascending order.
module h_decoder_64_57 (
    input  logic [63:0] i_CodeWord,
    output logic        o_ErrorC,
    output logic        o_ErrorD,
    output logic [56:0] o_DecodWord
);
    logic [5:0]  syn;
    logic        par;
    logic [63:0] cw_fix;
    int          k;

    always_comb begin
        syn         = '0;
        par         = ^i_CodeWord;
        cw_fix      = i_CodeWord;
        o_DecodWord = '0;
        k           = 0;
        for (int i = 1; i < 64; i++) begin
            if (i_CodeWord[i]) syn = syn ^ i[5:0];
        end
        // Odd overall parity means one flipped bit; the syndrome names it (0 = the parity bit itself).
        o_ErrorC = par;
        o_ErrorD = !par && (syn != 6'd0);
        if (par) cw_fix[syn] = ~cw_fix[syn];
        for (int i = 1; i < 64; i++) begin
            if ((i & (i - 1)) != 0) begin
                o_DecodWord[k] = cw_fix[i];
                k = k + 1;
            end
        end
    end
endmodule

module ecc_scrubber_64_57 #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic              i_Abort,
    input  logic              i_Continuous,
    input  logic              i_ClrCnt,
    output logic              o_MemReq,
    output logic [ADDR_W-1:0] o_MemAddr,
    input  logic              i_MemAck,
    input  logic [63:0]       i_MemData,
    output logic              o_FixReq,
    output logic [ADDR_W-1:0] o_FixAddr,
    output logic [57:0]       o_FixData,
    input  logic              i_FixAck,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [CNT_W-1:0]  o_CorrCnt,
    output logic [CNT_W-1:0]  o_UncorrCnt,
    output logic [ADDR_W-1:0] o_FirstErrAddr,
    output logic              o_FirstErrValid
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_FIX, S_NEXT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         data_q, data_d;
    logic [ADDR_W-1:0]   fix_addr_q, fix_addr_d;
    logic [57:0]         fix_data_q, fix_data_d;
    logic [CNT_W-1:0]    corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]    uncorr_cnt_q, uncorr_cnt_d;
    logic [ADDR_W-1:0]   first_addr_q, first_addr_d;
    logic                first_vld_q, first_vld_d;

    logic        dec_c, dec_d;
    logic [56:0] dec_word;
    logic        err_c, err_d;

    h_decoder_64_57 u_dec (
        .i_CodeWord  (data_q),
        .o_ErrorC    (dec_c),
        .o_ErrorD    (dec_d),
        .o_DecodWord (dec_word)
    );

    // Decoder flags only mean something while the captured word is being checked.
    assign err_c = (state_q == S_CHK) && dec_c;
    assign err_d = (state_q == S_CHK) && dec_d;

    // State register and datapath flops
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            fix_addr_q   <= '0;
            fix_data_q   <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            first_addr_q <= '0;
            first_vld_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            fix_addr_q   <= fix_addr_d;
            fix_data_q   <= fix_data_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            first_addr_q <= first_addr_d;
            first_vld_q  <= first_vld_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: if (i_Start) begin
                state_d = S_RD;
                addr_d  = '0;
            end
            S_RD:   if (i_MemAck) state_d = S_CHK;
            S_CHK:  state_d = dec_c ? S_FIX : S_NEXT;
            S_FIX:  if (i_FixAck) state_d = S_NEXT;
            S_NEXT: begin
                if (addr_q != LAST_ADDR) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_RD;
                end else if (i_Continuous) begin
                    addr_d  = '0;
                    state_d = S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (i_Abort) state_d = S_IDLE;
    end

    // Datapath: capture, write-back staging, counters and first-error capture
    always_comb begin
        data_d       = data_q;
        fix_addr_d   = fix_addr_q;
        fix_data_d   = fix_data_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        first_addr_d = first_addr_q;
        first_vld_d  = first_vld_q;

        if (state_q == S_RD && i_MemAck) data_d = i_MemData;

        if (err_c) begin
            fix_addr_d = addr_q;
            fix_data_d = {1'b0, dec_word};   // 57 data bits, zero-extended for the re-encoder
            if (corr_cnt_q != CNT_MAX) corr_cnt_d = corr_cnt_q + 1'b1;
        end
        if (err_d && uncorr_cnt_q != CNT_MAX) uncorr_cnt_d = uncorr_cnt_q + 1'b1;

        if ((err_c || err_d) && !first_vld_q) begin
            first_vld_d  = 1'b1;
            first_addr_d = addr_q;
        end

        // Clear overrides any same-cycle increment or capture.
        if (i_ClrCnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
            first_vld_d  = 1'b0;
            first_addr_d = '0;
        end
    end

    // Outputs
    always_comb begin
        o_MemReq        = (state_q == S_RD);
        o_MemAddr       = addr_q;
        o_FixReq        = (state_q == S_FIX);
        o_FixAddr       = fix_addr_q;
        o_FixData       = fix_data_q;
        o_Busy          = (state_q != S_IDLE);
        // An abort in the final NEXT cycle means the pass did not complete.
        o_Done          = (state_q == S_NEXT) && (addr_q == LAST_ADDR) && !i_Abort;
        o_CorrCnt       = corr_cnt_q;
        o_UncorrCnt     = uncorr_cnt_q;
        o_FirstErrAddr  = first_addr_q;
        o_FirstErrValid = first_vld_q;
    end
endmodule

// File: tb/tb_ecc_scrubber_64_57.sv
`timescale 1ns/1ps
module tb_ecc_scrubber_64_57;
    localparam int AW = 2;
    localparam int CW = 2;

    logic          i_Clk = 1'b0;
    logic          i_Rst = 1'b1;
    logic          i_Start = 1'b0, i_Abort = 1'b0, i_Continuous = 1'b0, i_ClrCnt = 1'b0;
    logic          o_MemReq;
    logic [AW-1:0] o_MemAddr;
    logic          i_MemAck = 1'b0;
    logic [63:0]   i_MemData = '0;
    logic          o_FixReq;
    logic [AW-1:0] o_FixAddr;
    logic [57:0]   o_FixData;
    logic          i_FixAck = 1'b0;
    logic          o_Busy, o_Done;
    logic [CW-1:0] o_CorrCnt, o_UncorrCnt;
    logic [AW-1:0] o_FirstErrAddr;
    logic          o_FirstErrValid;

    always #5 i_Clk = ~i_Clk;

    ecc_scrubber_64_57 #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Abort(i_Abort),
        .i_Continuous(i_Continuous), .i_ClrCnt(i_ClrCnt),
        .o_MemReq(o_MemReq), .o_MemAddr(o_MemAddr), .i_MemAck(i_MemAck), .i_MemData(i_MemData),
        .o_FixReq(o_FixReq), .o_FixAddr(o_FixAddr), .o_FixData(o_FixData), .i_FixAck(i_FixAck),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_CorrCnt(o_CorrCnt), .o_UncorrCnt(o_UncorrCnt),
        .o_FirstErrAddr(o_FirstErrAddr), .o_FirstErrValid(o_FirstErrValid)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [57:0]   d;
    } fix_t;

    int            vectors = 0;
    int            miscompares = 0;
    int            done_cnt = 0;
    bit            ack_en = 1'b0;
    bit            fix_ack_en = 1'b0;
    logic [63:0]   mem [4];
    logic [56:0]   mem_data [4];
    logic [AW-1:0] exp_rd_q [$];
    fix_t          exp_fix_q [$];

    // Reference SECDED encoder: data fills non-power-of-two positions 1..63,
    // Hamming parity at 2^b, overall parity at bit 0.
    function automatic logic [63:0] encode(input logic [56:0] d);
        logic [63:0] cw;
        logic [5:0]  s;
        int          k;
        cw = '0;
        k  = 0;
        for (int i = 1; i < 64; i++)
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[k];
                k++;
            end
        s = '0;
        for (int i = 1; i < 64; i++) if (cw[i]) s = s ^ i[5:0];
        for (int b = 0; b < 6; b++) cw[1 << b] = s[b];
        cw[0] = ^cw[63:1];
        return cw;
    endfunction

    task automatic set_word(input int a, input logic [56:0] d, input logic [63:0] flip);
        mem_data[a] = d;
        mem[a]      = encode(d) ^ flip;
    endtask

    task automatic load_clean();
        set_word(0, 57'h0123456789ABCDE, '0);
        set_word(1, 57'h1F0E0D0C0B0A090, '0);
        set_word(2, 57'h0AAAA5555AAAA55, '0);
        set_word(3, 57'h100000000000001, '0);
    endtask

    task automatic push_pass();
        for (int a = 0; a < 4; a++) exp_rd_q.push_back(a[AW-1:0]);
    endtask

    // Memory and write-back responder: acks on the first request cycle and scores each accepted transfer.
    initial begin
        fix_t     ef;
        logic [AW-1:0] ea;
        forever begin
            @(negedge i_Clk);
            i_MemAck = 1'b0;
            i_FixAck = 1'b0;
            if (!i_Rst && o_MemReq && ack_en) begin
                i_MemAck  = 1'b1;
                i_MemData = mem[o_MemAddr];
                vectors++;
                if (exp_rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_addr: unexpected read of addr %0d, none expected", o_MemAddr);
                end else begin
                    ea = exp_rd_q.pop_front();
                    if (o_MemAddr !== ea) begin
                        miscompares++;
                        $display("FAIL rd_addr: got %0d expected %0d", o_MemAddr, ea);
                    end
                end
            end
            if (!i_Rst && o_FixReq && fix_ack_en) begin
                i_FixAck = 1'b1;
                vectors++;
                if (exp_fix_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL fix_req: unexpected write-back addr %0d data %h", o_FixAddr, o_FixData);
                end else begin
                    ef = exp_fix_q.pop_front();
                    if (o_FixAddr !== ef.a || o_FixData !== ef.d) begin
                        miscompares++;
                        $display("FAIL fix_req: got addr %0d data %h expected addr %0d data %h",
                                 o_FixAddr, o_FixData, ef.a, ef.d);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge i_Clk);
        if (o_Done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic pulse_start();
        @(negedge i_Clk) i_Start = 1'b1;
        @(negedge i_Clk) i_Start = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge i_Clk) i_ClrCnt = 1'b1;
        @(negedge i_Clk) i_ClrCnt = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the start edge; returns at the negedge where o_Done is high.
    task automatic wait_done(input int max, output int n, output bit ok);
        n = 1;
        while (o_Done !== 1'b1 && n < max) begin
            @(negedge i_Clk);
            n++;
        end
        ok = (o_Done === 1'b1);
    endtask

    task automatic wait_rd(input logic [AW-1:0] a, output bit ok);
        int n;
        n = 0;
        while (!(o_MemReq === 1'b1 && o_MemAddr === a) && n < 60) begin
            @(negedge i_Clk);
            n++;
        end
        ok = (o_MemReq === 1'b1 && o_MemAddr === a);
    endtask

    task automatic test_reset();
        i_Rst = 1'b1;
        repeat (2) @(negedge i_Clk);
        vectors++;
        if ({o_MemReq, o_FixReq, o_Busy, o_Done, o_FirstErrValid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000", {o_MemReq, o_FixReq, o_Busy, o_Done, o_FirstErrValid});
        end
        vectors++;
        if ({o_CorrCnt, o_UncorrCnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt: got corr %0d uncorr %0d expected 0 0", o_CorrCnt, o_UncorrCnt);
        end
        vectors++;
        if ({o_MemAddr, o_FixAddr, o_FirstErrAddr} !== '0 || o_FixData !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: got mem %0d fix %0d first %0d data %h expected all 0",
                     o_MemAddr, o_FixAddr, o_FirstErrAddr, o_FixData);
        end
        @(negedge i_Clk) i_Rst = 1'b0;
    endtask

    task automatic test_clean_pass();
        int n, d0;
        bit ok;
        load_clean();
        ack_en = 1'b1;
        fix_ack_en = 1'b1;
        d0 = done_cnt;
        push_pass();
        pulse_start();
        wait_done(100, n, ok);
        vectors++;
        if (!ok || n != 12) begin
            miscompares++;
            $display("FAIL clean_done_cycle: got cycle %0d (seen %0d) expected 12", n, ok);
        end
        @(negedge i_Clk);
        vectors++;
        if (o_Busy !== 1'b0 || o_CorrCnt !== 0 || o_UncorrCnt !== 0 || o_FirstErrValid !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_status: got busy %b corr %0d uncorr %0d fev %b expected 0 0 0 0",
                     o_Busy, o_CorrCnt, o_UncorrCnt, o_FirstErrValid);
        end
        vectors++;
        if (exp_rd_q.size() != 0 || done_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL clean_reads: got %0d reads left, %0d done pulses expected 0, 1",
                     exp_rd_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_correctable();
        int n;
        bit ok;
        logic [63:0] flip;
        load_clean();
        flip = 64'd1 << $urandom_range(0, 63);
        set_word(2, 57'h0123456789ABCDE, flip);
        fix_ack_en = 1'b0;
        push_pass();
        exp_fix_q.push_back('{a: 2'd2, d: {1'b0, 57'h0123456789ABCDE}});
        pulse_start();
        n = 0;
        while (o_FixReq !== 1'b1 && n < 50) begin
            @(negedge i_Clk);
            n++;
        end
        vectors++;
        if (o_FixReq !== 1'b1 || o_FixAddr !== 2'd2 || o_FixData !== {1'b0, 57'h0123456789ABCDE}) begin
            miscompares++;
            $display("FAIL corr_fix: got req %b addr %0d data %h expected 1 2 %h",
                     o_FixReq, o_FixAddr, o_FixData, {1'b0, 57'h0123456789ABCDE});
        end
        vectors++;
        if (o_CorrCnt !== 2'd1 || o_FirstErrValid !== 1'b1 || o_FirstErrAddr !== 2'd2) begin
            miscompares++;
            $display("FAIL corr_cnt: got corr %0d fev %b fea %0d expected 1 1 2",
                     o_CorrCnt, o_FirstErrValid, o_FirstErrAddr);
        end
        repeat (5) @(negedge i_Clk);
        vectors++;
        if (o_FixReq !== 1'b1 || o_MemReq !== 1'b0 || o_FixAddr !== 2'd2) begin
            miscompares++;
            $display("FAIL corr_hold: got fixreq %b memreq %b addr %0d expected 1 0 2", o_FixReq, o_MemReq, o_FixAddr);
        end
        fix_ack_en = 1'b1;
        wait_done(100, n, ok);
        @(negedge i_Clk);
        vectors++;
        if (!ok || exp_fix_q.size() != 0 || exp_rd_q.size() != 0 || o_CorrCnt !== 2'd1 || o_UncorrCnt !== 2'd0) begin
            miscompares++;
            $display("FAIL corr_end: got done %b fix left %0d rd left %0d corr %0d uncorr %0d expected 1 0 0 1 0",
                     ok, exp_fix_q.size(), exp_rd_q.size(), o_CorrCnt, o_UncorrCnt);
        end
    endtask

    task automatic test_uncorrectable();
        int n;
        bit ok;
        logic [63:0] flip;
        pulse_clr();
        vectors++;
        if (o_CorrCnt !== 0 || o_UncorrCnt !== 0 || o_FirstErrValid !== 1'b0) begin
            miscompares++;
            $display("FAIL clr: got corr %0d uncorr %0d fev %b expected 0 0 0", o_CorrCnt, o_UncorrCnt, o_FirstErrValid);
        end
        load_clean();
        flip = (64'd1 << $urandom_range(0, 31)) | (64'd1 << $urandom_range(32, 63));
        set_word(1, 57'h1F0E0D0C0B0A090, flip);
        fix_ack_en = 1'b1;
        push_pass();
        pulse_start();
        wait_done(100, n, ok);
        vectors++;
        if (!ok || n != 12) begin
            miscompares++;
            $display("FAIL uncorr_done_cycle: got cycle %0d (seen %0d) expected 12", n, ok);
        end
        @(negedge i_Clk);
        vectors++;
        if (o_UncorrCnt !== 2'd1 || o_CorrCnt !== 2'd0 || o_FirstErrValid !== 1'b1 || o_FirstErrAddr !== 2'd1) begin
            miscompares++;
            $display("FAIL uncorr_cnt: got uncorr %0d corr %0d fev %b fea %0d expected 1 0 1 1",
                     o_UncorrCnt, o_CorrCnt, o_FirstErrValid, o_FirstErrAddr);
        end
    endtask

    task automatic test_saturation();
        int n;
        bit ok;
        pulse_clr();
        for (int a = 0; a < 4; a++)
            set_word(a, 57'h0AAAA5555AAAA55 ^ 57'(a * 7919), 64'd1 << $urandom_range(0, 63));
        fix_ack_en = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 4; a++) begin
                exp_rd_q.push_back(a[AW-1:0]);
                exp_fix_q.push_back('{a: a[AW-1:0], d: {1'b0, mem_data[a]}});
            end
        pulse_start();
        wait_done(100, n, ok);
        @(negedge i_Clk);
        vectors++;
        if (!ok || o_CorrCnt !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_4: got corr %0d (done %b) expected 3", o_CorrCnt, ok);
        end
        pulse_start();
        wait_rd(2'd1, ok);
        vectors++;
        if (!ok || o_CorrCnt !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_5: got corr %0d (rd seen %b) expected 3", o_CorrCnt, ok);
        end
        @(negedge i_Clk) i_ClrCnt = 1'b1;   // now in CHK of the 6th error
        @(negedge i_Clk) i_ClrCnt = 1'b0;
        vectors++;
        if (o_CorrCnt !== 2'd0 || o_FirstErrValid !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clr: got corr %0d fev %b expected 0 0", o_CorrCnt, o_FirstErrValid);
        end
        wait_done(100, n, ok);
        @(negedge i_Clk);
        vectors++;
        if (!ok || o_CorrCnt !== 2'd2 || o_FirstErrAddr !== 2'd2 || exp_fix_q.size() != 0 || exp_rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL sat_end: got corr %0d fea %0d fix left %0d rd left %0d expected 2 2 0 0",
                     o_CorrCnt, o_FirstErrAddr, exp_fix_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic test_abort();
        int n, d0;
        bit ok;
        load_clean();
        ack_en = 1'b0;
        d0 = done_cnt;
        pulse_start();
        repeat (3) @(negedge i_Clk);
        vectors++;
        if (o_MemReq !== 1'b1 || o_MemAddr !== 2'd0 || o_Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_rd_hold: got req %b addr %0d busy %b expected 1 0 1", o_MemReq, o_MemAddr, o_Busy);
        end
        i_Abort = 1'b1;
        @(negedge i_Clk) i_Abort = 1'b0;
        vectors++;
        if (o_MemReq !== 1'b0 || o_Busy !== 1'b0 || o_FixReq !== 1'b0 || done_cnt != d0 || o_CorrCnt !== 2'd2) begin
            miscompares++;
            $display("FAIL abort_idle: got req %b busy %b fix %b done %0d corr %0d expected 0 0 0 0 2",
                     o_MemReq, o_Busy, o_FixReq, done_cnt - d0, o_CorrCnt);
        end
        i_Abort = 1'b1;
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Abort = 1'b0;
        i_Start = 1'b0;
        vectors++;
        if (o_Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_start: got busy %b expected 0", o_Busy);
        end
        ack_en = 1'b1;
        push_pass();
        pulse_start();
        repeat (4) @(negedge i_Clk);
        i_Start = 1'b1;                      // must be ignored while busy
        @(negedge i_Clk) i_Start = 1'b0;
        wait_done(100, n, ok);
        @(negedge i_Clk);
        vectors++;
        if (!ok || exp_rd_q.size() != 0 || done_cnt != d0 + 1 || o_Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_restart: got done %b rd left %0d pulses %0d busy %b expected 1 0 1 0",
                     ok, exp_rd_q.size(), done_cnt - d0, o_Busy);
        end
    endtask

    task automatic test_continuous();
        int n, d0;
        bit ok, busy_drop;
        pulse_clr();
        load_clean();
        set_word(3, 57'h100000000000001, 64'd1 << 40);
        ack_en = 1'b1;
        fix_ack_en = 1'b1;
        i_Continuous = 1'b1;
        d0 = done_cnt;
        push_pass();
        exp_rd_q.push_back(2'd0);
        exp_rd_q.push_back(2'd1);
        exp_fix_q.push_back('{a: 2'd3, d: {1'b0, 57'h100000000000001}});
        pulse_start();
        busy_drop = 1'b0;
        n = 1;
        while (o_Done !== 1'b1 && n < 100) begin
            @(negedge i_Clk);
            if (o_Busy !== 1'b1) busy_drop = 1'b1;
            n++;
        end
        ok = (o_Done === 1'b1);
        @(negedge i_Clk);
        vectors++;
        if (!ok || busy_drop || o_MemReq !== 1'b1 || o_MemAddr !== 2'd0 || o_Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL cont_wrap: got done %b busydrop %b req %b addr %0d busy %b expected 1 0 1 0 1",
                     ok, busy_drop, o_MemReq, o_MemAddr, o_Busy);
        end
        i_Continuous = 1'b0;
        wait_rd(2'd1, ok);
        @(negedge i_Clk);
        i_Rst = 1'b1;
        #1;
        vectors++;
        if ({o_MemReq, o_FixReq, o_Busy, o_Done, o_FirstErrValid} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_mid_flags: got %b expected 00000", {o_MemReq, o_FixReq, o_Busy, o_Done, o_FirstErrValid});
        end
        vectors++;
        if ({o_CorrCnt, o_UncorrCnt} !== '0 || {o_MemAddr, o_FixAddr, o_FirstErrAddr} !== '0 || o_FixData !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_vals: got corr %0d uncorr %0d mem %0d fix %0d first %0d data %h expected all 0",
                     o_CorrCnt, o_UncorrCnt, o_MemAddr, o_FixAddr, o_FirstErrAddr, o_FixData);
        end
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b0;
        repeat (3) @(negedge i_Clk);
        vectors++;
        if (!ok || exp_rd_q.size() != 0 || exp_fix_q.size() != 0 || done_cnt != d0 + 1 || o_Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_after: got rd seen %b rd left %0d fix left %0d pulses %0d busy %b expected 1 0 0 1 0",
                     ok, exp_rd_q.size(), exp_fix_q.size(), done_cnt - d0, o_Busy);
        end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_correctable();
        test_uncorrectable();
        test_saturation();
        test_abort();
        test_continuous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
